// File: rtl/button_event.sv
// Button event generator: turns debounced button levels into single-cycle
// press / release / long-press / auto-repeat pulses, one FSM per channel.

// Per-channel event FSM with its own hold counter. Every output is registered.
module button_event_lane #(
    parameter int LONG_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int CNT_W         = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic press_p,
    output logic rel_p,
    output logic long_p,
    output logic rep_p,
    output logic held
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Terminal counts. With repeat disabled the repeat terminal is never used,
    // so it is pinned to 0 instead of underflowing.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, rel_d, long_d, rep_d, held_d;

    // Next-state, counter and next-output decode. A low level always wins
    // over a threshold reached on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pb) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!pb) begin
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!pb) begin
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (REPEAT_CYCLES == 0) begin
                    cnt_d = '0;
                end else if (cnt_q == REP_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_p <= 1'b0;
            rel_p   <= 1'b0;
            long_p  <= 1'b0;
            rep_p   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_p <= press_d;
            rel_p   <= rel_d;
            long_p  <= long_d;
            rep_p   <= rep_d;
            held    <= held_d;
        end
    end
endmodule

// Top: WIDTH independent channels, each an instance of the lane FSM.
module button_event #(
    parameter int WIDTH         = 1,
    parameter int LONG_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pb_db,
    output logic [WIDTH-1:0] press_p,
    output logic [WIDTH-1:0] rel_p,
    output logic [WIDTH-1:0] long_p,
    output logic [WIDTH-1:0] rep_p,
    output logic [WIDTH-1:0] held
);
    // Counter is sized for the larger of the two intervals, at least 1 bit.
    localparam int MAX_C = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = $clog2((MAX_C > 2) ? MAX_C : 2);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        button_event_lane #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .pb     (pb_db[i]),
            .press_p(press_p[i]),
            .rel_p  (rel_p[i]),
            .long_p (long_p[i]),
            .rep_p  (rep_p[i]),
            .held   (held[i])
        );
    end
endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: a 2-channel DUT (LONG=4, REPEAT=2) and a 1-channel
// DUT with repeat disabled, checked every cycle against a run-length model.
module tb_button_event;
    localparam int W = 2;
    localparam int L = 4;
    localparam int R = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pb = '0;
    logic         pb2 = 1'b0;
    logic [W-1:0] a_press, a_rel, a_long, a_rep, a_held;
    logic         b_press, b_rel, b_long, b_rep, b_held;
    logic [14:0]  obs;

    int total = 0;
    int bad   = 0;

    // Model: h[c] is the number of consecutive sampled-high edges on channel c
    // since the last low sample or reset. Channel 2 is the repeat-disabled DUT.
    int          h [3];
    logic [2:0]  ep, er, el, erp, eh;

    button_event #(.WIDTH(W), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut_a (
        .clk(clk), .rst_n(rst_n), .pb_db(pb),
        .press_p(a_press), .rel_p(a_rel), .long_p(a_long), .rep_p(a_rep), .held(a_held)
    );

    button_event #(.WIDTH(1), .LONG_CYCLES(L), .REPEAT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pb_db(pb2),
        .press_p(b_press), .rel_p(b_rel), .long_p(b_long), .rep_p(b_rep), .held(b_held)
    );

    assign obs = {b_held, b_rep, b_long, b_rel, b_press,
                  a_held, a_rep, a_long, a_rel, a_press};

    always #5 clk = ~clk;

    function automatic logic [14:0] expv();
        return {eh[2], erp[2], el[2], er[2], ep[2],
                eh[1:0], erp[1:0], el[1:0], er[1:0], ep[1:0]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) h[c] = 0;
        ep = '0; er = '0; el = '0; erp = '0; eh = '0;
    endtask

    // Outputs after an edge, derived from the run length alone.
    task automatic model_edge(input logic [2:0] s);
        for (int c = 0; c < 3; c++) begin
            int rr;
            rr = (c == 2) ? 0 : R;
            if (s[c]) begin
                h[c]  = h[c] + 1;
                er[c] = 1'b0;
            end else begin
                er[c] = (h[c] > 0);
                h[c]  = 0;
            end
            ep[c]  = (h[c] == 1);
            eh[c]  = (h[c] >= 1);
            el[c]  = (h[c] == L + 1);
            erp[c] = (rr > 0) && (h[c] > L + 1) && ((h[c] - L - 1) % rr == 0);
        end
    endtask

    // Drive levels, take one edge, advance the model, settle 1 time unit.
    task automatic tick(input logic [1:0] p, input logic p2);
        pb  = p;
        pb2 = p2;
        @(posedge clk);
        model_edge({p2, p});
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("FAIL reset_async obs=%b exp=%b", obs, 15'd0);
        end
        @(posedge clk); #1;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("FAIL reset_hold obs=%b exp=%b", obs, 15'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(2'b00, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL reset_idle k=%0d obs=%b exp=%b", k, obs, expv());
            end
        end
    endtask

    task automatic test_short_press();
        int np = 0, nr = 0, nl = 0, n1 = 0;
        for (int k = 0; k < 7; k++) begin
            tick((k < 3) ? 2'b01 : 2'b00, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL short k=%0d obs=%b exp=%b", k, obs, expv());
            end
            np += int'(a_press[0]); nr += int'(a_rel[0]); nl += int'(a_long[0]);
            n1 += int'(a_press[1] | a_rel[1] | a_long[1] | a_rep[1] | a_held[1]);
        end
        total++;
        if (np !== 1 || nr !== 1 || nl !== 0 || n1 !== 0) begin
            bad++; $display("FAIL short_counts press=%0d rel=%0d long=%0d ch1=%0d exp 1 1 0 0", np, nr, nl, n1);
        end
    endtask

    task automatic test_long_repeat();
        int nl = 0, nrp = 0, nr = 0;
        for (int k = 0; k < 16; k++) begin
            tick((k < 12) ? 2'b01 : 2'b00, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL long_rep k=%0d obs=%b exp=%b", k, obs, expv());
            end
            nl += int'(a_long[0]); nrp += int'(a_rep[0]); nr += int'(a_rel[0]);
        end
        total++;
        if (nl !== 1 || nrp !== 3 || nr !== 1) begin
            bad++; $display("FAIL long_rep_counts long=%0d rep=%0d rel=%0d exp 1 3 1", nl, nrp, nr);
        end
    endtask

    task automatic test_release_at_threshold();
        int nl = 0, nr = 0;
        for (int k = 0; k < L + 3; k++) begin
            tick((k < L) ? 2'b01 : 2'b00, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL thresh k=%0d obs=%b exp=%b", k, obs, expv());
            end
            nl += int'(a_long[0]); nr += int'(a_rel[0]);
        end
        total++;
        if (nl !== 0 || nr !== 1) begin
            bad++; $display("FAIL thresh_counts long=%0d rel=%0d exp 0 1", nl, nr);
        end
    endtask

    task automatic test_no_repeat();
        int nl = 0, nrp = 0, nr = 0;
        for (int k = 0; k < 23; k++) begin
            tick(2'b00, (k < 20));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL norep k=%0d obs=%b exp=%b", k, obs, expv());
            end
            nl += int'(b_long); nrp += int'(b_rep); nr += int'(b_rel);
        end
        total++;
        if (nl !== 1 || nrp !== 0 || nr !== 1) begin
            bad++; $display("FAIL norep_counts long=%0d rep=%0d rel=%0d exp 1 0 1", nl, nrp, nr);
        end
    endtask

    task automatic test_two_channels();
        for (int k = 0; k < 12; k++) begin
            tick({(k < 3), (k < 8)}, 1'b0);
            if (k == 0) begin
                total++;
                if (a_press !== 2'b11) begin
                    bad++; $display("FAIL dual_press obs=%b exp=%b", a_press, 2'b11);
                end
            end
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL dual k=%0d obs=%b exp=%b", k, obs, expv());
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        for (int k = 0; k < L + 4; k++) tick(2'b01, 1'b1);
        total++;
        if (a_held[0] !== 1'b1 || b_held !== 1'b1) begin
            bad++; $display("FAIL midrst_pre held=%b/%b exp 1/1", a_held[0], b_held);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("FAIL midrst_async obs=%b exp=%b", obs, 15'd0);
        end
        @(posedge clk); #1;
        total++;
        if (obs !== 15'd0) begin
            bad++; $display("FAIL midrst_hold obs=%b exp=%b", obs, 15'd0);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < L + 3; k++) begin
            tick(2'b01, 1'b1);
            if (k == 0 || k == L) begin
                total++;
                if ({a_press[0], a_long[0]} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL midrst_after k=%0d press=%b long=%b", k, a_press[0], a_long[0]);
                end
            end
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL midrst k=%0d obs=%b exp=%b", k, obs, expv());
            end
        end
        tick(2'b00, 1'b0);
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL midrst_rel obs=%b exp=%b", obs, expv());
        end
    endtask

    task automatic test_random();
        logic [2:0] s = '0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 6) == 0) s[c] = ~s[c];
            tick(s[1:0], s[2]);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL random k=%0d obs=%b exp=%b", k, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_release_at_threshold();
        test_no_repeat();
        test_two_channels();
        test_reset_mid_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
